simd_upstream_packetizer: RTL
=============================

# simd_upstream_packetizer

Builds upstream stack-bus packets from SIMD result words and drives the SIMD-side upstream port of the PE stack interface (`sui__sti__*`). The SIMD issues a send command (length, type, OOB word), then streams result words into an 8-entry FIFO. The block frames those words with SOP/MOP/EOP/SOM control codes and honours `sti__sui__ready` backpressure. It sits between the SIMD core and the stack interface inside each PE.

## Interface
Parameters:
- FIFO_DEPTH, 8, data-word FIFO entries (power of two)

Ports:
- clk  in  1  PE clock
- reset_poweron  in  1  asynchronous, active-low reset
- simd__sui__cmd_valid  in  1  send-command valid
- sui__simd__cmd_ready  out  1  command accepted when both are high
- simd__sui__cmd_len  in  8  data words in packet; 0 encodes 256
- simd__sui__cmd_type  in  `STACK_UP_INTF_TYPE_RANGE`  packet type, held on all beats
- simd__sui__cmd_oob  in  `STACK_UP_INTF_OOB_DATA_RANGE`  OOB word, held on all beats
- simd__sui__valid  in  1  result word valid
- sui__simd__ready  out  1  FIFO not full
- simd__sui__data  in  `STACK_UP_INTF_DATA_RANGE`  result word
- sui__sti__valid / sui__sti__cntl / sui__sti__type / sui__sti__data / sui__sti__oob_data  out  1 / `COMMON_STD_INTF_CNTL_RANGE` / type / data / OOB  upstream beat
- sti__sui__ready  in  1  stack interface ready
- sui__simd__pkt_done  out  1  one-cycle pulse after the final beat of a packet

## Operation
- Control codes on cntl: SOP=2'b01, MOP=2'b00, EOP=2'b10, SOM=2'b11.
- FSM states: IDLE, SEND, CKSUM. CKSUM exists only with the macro enabled.
- IDLE: cmd_ready=1. On a command handshake, latch len, type and oob, load the remaining count, and go to SEND.
- SEND: cmd_ready=0. sti valid = FIFO non-empty. Data = FIFO head.
  - cntl is SOM when len==1.
  - Otherwise cntl is SOP on the first beat, EOP when remaining==1, and MOP in between.
- Each sti handshake pops the FIFO and decrements the remaining count. After the last-beat handshake the FSM returns to IDLE and pkt_done pulses.
- The FIFO accepts words in any state, including before a command arrives. Prefetched words are consumed by the next packet.
- Words beyond the commanded length stay in the FIFO for the next packet.
- ready = !full. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
- Bubbles are allowed: valid may drop mid-packet when the FIFO is empty.
- While valid && !ready, data, cntl, type and oob stay stable.
- Length arithmetic: the 9-bit count is loaded with 256 when cmd_len==0.
- FIFO pointers wrap modulo FIFO_DEPTH. An extra pointer bit distinguishes full from empty.

## Timing
- Reset values: every output is 0, except cmd_ready=1 and sui__simd__ready=1. FSM resets to IDLE, FIFO is empty.
- Reset asserted mid-packet flushes the FIFO and aborts the packet with no EOP.
- Latency: a word pushed into an empty FIFO in SEND at cycle N appears on sui__sti__* at N+1.
- The first beat of a packet can appear no earlier than the cycle after the command handshake.
- pkt_done is asserted the cycle after the final handshake, for exactly one cycle. cmd_ready returns to 1 in that same cycle.
- Throughput: one beat per cycle while the FIFO is non-empty and ready is held high.

## Configuration
- `SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN` defined:
  - An XOR accumulator clears on command accept and folds in every data beat handshaken.
  - The last data beat carries MOP, or SOP when len==1.
  - The FSM then enters CKSUM and presents the accumulator with cntl=EOP, valid=1, and type/oob held.
  - The handshake on that beat ends the packet. Packet length on the bus is len+1.
- Undefined: no CKSUM state, no accumulator, framing exactly as in Operation.

## Test plan
- Reset, then cmd len=4, type=1, oob=0xA5, with words 0x10..0x13 and ready held 1 → four consecutive beats, cntl 01,00,00,10, oob 0xA5 on each; pkt_done pulses the cycle after beat 4.
- Cmd len=1, word 0x77 → one beat, cntl=11, data 0x77. With the macro enabled: beat 0x77 with cntl=01, then beat 0x77 with cntl=10.
- Push 8 words with no command → sui__simd__ready=0 after the 8th push and the 9th is refused. Cmd len=8 then emits all 8 in order.
- Cmd len=3 with ready toggled 1,0,0,1,1 → beat 2 is held stable with identical data and cntl through both stall cycles; total 3 handshakes.
- Cmd len=0, 256 words streamed → 256 beats, SOP first, EOP on beat 256, count wrap correct.
- Assert reset after beat 2 of a len=5 packet → all outputs 0, FIFO empty, cmd_ready=1. The next len=2 packet starts with SOP.

Source files
------------

// File: rtl/simd_upstream_packetizer.sv
// Frames SIMD result words into upstream stack-bus packets (SOP/MOP/EOP/SOM) behind an 8-entry FIFO.
// Optional trailing XOR checksum beat: define SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN.
`ifndef STACK_UP_INTF_TYPE_RANGE
`define STACK_UP_INTF_TYPE_RANGE 1:0
`endif
`ifndef STACK_UP_INTF_DATA_RANGE
`define STACK_UP_INTF_DATA_RANGE 31:0
`endif
`ifndef STACK_UP_INTF_OOB_DATA_RANGE
`define STACK_UP_INTF_OOB_DATA_RANGE 7:0
`endif
`ifndef COMMON_STD_INTF_CNTL_RANGE
`define COMMON_STD_INTF_CNTL_RANGE 1:0
`endif

module simd_upstream_packetizer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_poweron,
    input  logic                                   simd__sui__cmd_valid,
    output logic                                   sui__simd__cmd_ready,
    input  logic [7:0]                             simd__sui__cmd_len,
    input  logic [`STACK_UP_INTF_TYPE_RANGE]       simd__sui__cmd_type,
    input  logic [`STACK_UP_INTF_OOB_DATA_RANGE]   simd__sui__cmd_oob,
    input  logic                                   simd__sui__valid,
    output logic                                   sui__simd__ready,
    input  logic [`STACK_UP_INTF_DATA_RANGE]       simd__sui__data,
    output logic                                   sui__sti__valid,
    output logic [`COMMON_STD_INTF_CNTL_RANGE]     sui__sti__cntl,
    output logic [`STACK_UP_INTF_TYPE_RANGE]       sui__sti__type,
    output logic [`STACK_UP_INTF_DATA_RANGE]       sui__sti__data,
    output logic [`STACK_UP_INTF_OOB_DATA_RANGE]   sui__sti__oob_data,
    input  logic                                   sti__sui__ready,
    output logic                                   sui__simd__pkt_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] CNTL_MOP = 2'b00;
    localparam logic [1:0] CNTL_SOP = 2'b01;
    localparam logic [1:0] CNTL_EOP = 2'b10;
    localparam logic [1:0] CNTL_SOM = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
        , CKSUM = 2'd2
`endif
    } state_t;

    state_t                               state_q;
    logic                                 cmd_ready_q;
    logic                                 done_q;
    logic [8:0]                           len_q;
    logic [8:0]                           rem_q;
    logic [`STACK_UP_INTF_TYPE_RANGE]     type_q;
    logic [`STACK_UP_INTF_OOB_DATA_RANGE] oob_q;
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
    logic [`STACK_UP_INTF_DATA_RANGE]     acc_q;
`endif

    // FIFO: the extra pointer bit separates full from empty when the indices match
    logic [`STACK_UP_INTF_DATA_RANGE] mem_q [FIFO_DEPTH];
    logic [AW:0]                      wr_ptr_q, rd_ptr_q;
    logic                             empty, full, push, pop;
    logic [`STACK_UP_INTF_DATA_RANGE] head;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = simd__sui__valid && !full;
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    logic cmd_hs, send_hs, last_beat;
    logic [8:0] cmd_len9;

    assign cmd_hs    = simd__sui__cmd_valid && cmd_ready_q;
    assign send_hs   = (state_q == SEND) && !empty && sti__sui__ready;
    assign pop       = send_hs;
    assign last_beat = (rem_q == 9'd1);
    assign cmd_len9  = (simd__sui__cmd_len == 8'd0) ? 9'd256 : {1'b0, simd__sui__cmd_len};

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= simd__sui__data;
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_poweron) begin
        if (!reset_poweron) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            len_q       <= '0;
            rem_q       <= '0;
            type_q      <= '0;
            oob_q       <= '0;
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
            acc_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_hs) begin
                        len_q       <= cmd_len9;
                        rem_q       <= cmd_len9;
                        type_q      <= simd__sui__cmd_type;
                        oob_q       <= simd__sui__cmd_oob;
                        cmd_ready_q <= 1'b0;
                        state_q     <= SEND;
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
                        acc_q       <= '0;
`endif
                    end
                end
                SEND: begin
                    if (send_hs) begin
                        rem_q <= rem_q - 9'd1;
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
                        acc_q <= acc_q ^ head;
                        if (last_beat) state_q <= CKSUM;
`else
                        if (last_beat) begin
                            state_q     <= IDLE;
                            cmd_ready_q <= 1'b1;
                            done_q      <= 1'b1;
                        end
`endif
                    end
                end
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
                CKSUM: begin
                    if (sti__sui__ready) begin
                        state_q     <= IDLE;
                        cmd_ready_q <= 1'b1;
                        done_q      <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    // Framing is a pure function of registered state, so a stalled beat holds steady
    logic [1:0]                       cntl_d;
    logic                             valid_d;
    logic [`STACK_UP_INTF_DATA_RANGE] data_d;

    always_comb begin
        cntl_d  = CNTL_MOP;
        valid_d = 1'b0;
        data_d  = '0;
        if (state_q == SEND && !empty) begin
            valid_d = 1'b1;
            data_d  = head;
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
            if (len_q == 9'd1 || rem_q == len_q) cntl_d = CNTL_SOP;
            else                                 cntl_d = CNTL_MOP;
`else
            if (len_q == 9'd1)       cntl_d = CNTL_SOM;
            else if (rem_q == len_q) cntl_d = CNTL_SOP;
            else if (last_beat)      cntl_d = CNTL_EOP;
            else                     cntl_d = CNTL_MOP;
`endif
        end
`ifdef SIMD_UPSTREAM_PACKETIZER_CHECKSUM_EN
        else if (state_q == CKSUM) begin
            valid_d = 1'b1;
            data_d  = acc_q;
            cntl_d  = CNTL_EOP;
        end
`endif
    end

    assign sui__simd__cmd_ready = cmd_ready_q;
    assign sui__simd__ready     = !full;
    assign sui__simd__pkt_done  = done_q;
    assign sui__sti__valid      = valid_d;
    assign sui__sti__cntl       = cntl_d;
    assign sui__sti__data       = data_d;
    assign sui__sti__type       = type_q;
    assign sui__sti__oob_data   = oob_q;

endmodule
